// File: rtl/fetch_decode_queue_pkg.sv
// Shared constants and entry type for the IF->ID instruction buffer.
package fetch_decode_queue_pkg;
  localparam int XLEN = 32;
  localparam int FDQ_DEPTH = 4;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fdq_entry_t;

  // Sequential next-PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side push and decode-side pop handshakes plus flush and occupancy.
interface fetch_decode_queue_if
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = FDQ_DEPTH
);
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         in_instr;
  logic [XLEN-1:0]         in_pc;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_instr;
  logic [XLEN-1:0]         out_pc;
  logic [XLEN-1:0]         out_pc_plus4;
  logic                    flush;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc, out_pc_plus4, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc, out_pc_plus4, count
  );
endinterface

// File: rtl/fetch_decode_queue_chk.sv
// Occupancy and pop-legality assertions for the fetch/decode queue.
module fetch_decode_queue_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  input logic [$clog2(DEPTH):0] count,
  input logic                   pop
);
  localparam int CW = $clog2(DEPTH) + 1;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == CW'(0)));
endmodule

// File: rtl/fetch_decode_queue.sv
// Elastic IF->ID buffer: circular storage, count-based full/empty, flush drops all entries.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = FDQ_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  fetch_decode_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fdq_entry_t       mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_r;
  logic             push;
  logic             pop;
  fdq_entry_t       head;

  assign push = q.in_valid & q.in_ready;
  assign pop  = q.out_valid & q.out_ready;

  // Pointer and occupancy state; flush overrides any same-edge push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= PW'(0);
      wr_ptr  <= PW'(0);
      count_r <= CW'(0);
    end else if (q.flush) begin
      rd_ptr  <= wr_ptr;
      count_r <= CW'(0);
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents survive reset and flush, only validity is tracked.
  always_ff @(posedge clk) begin
    if (push && !q.flush) mem[wr_ptr] <= '{instr: q.in_instr, pc: q.in_pc};
  end

  // Head selection and NOP masking; everything here derives from registered state.
  always_comb begin
    head           = mem[rd_ptr];
    q.count        = count_r;
    q.in_ready     = (count_r != CW'(DEPTH));
    q.out_valid    = 1'b0;
    q.out_instr    = NOP_INSN;
    q.out_pc       = {XLEN{1'b0}};
    q.out_pc_plus4 = {XLEN{1'b0}};
    if (count_r != CW'(0)) begin
      q.out_valid    = 1'b1;
      q.out_instr    = head.instr;
      q.out_pc       = head.pc;
      q.out_pc_plus4 = pc_plus4(head.pc);
    end else begin
      q.out_valid    = 1'b0;
    end
  end

  fetch_decode_queue_chk #(.DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .count (count_r),
    .pop   (pop)
  );
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed and randomized stimulus against a queue-based reference of the fetch/decode buffer.
module tb_fetch_decode_queue;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [63:0] mq[$];

  fetch_decode_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    if (mq.size() == 0) begin
      e_instr = 32'h00000013;
      e_pc    = 32'h0;
      e_pc4   = 32'h0;
    end else begin
      e_instr = mq[0][63:32];
      e_pc    = mq[0][31:0];
      e_pc4   = e_pc + 32'd4;
    end
    check_eq("out_valid", {31'b0, bus.out_valid}, {31'b0, mq.size() != 0});
    check_eq("out_instr", bus.out_instr, e_instr);
    check_eq("out_pc", bus.out_pc, e_pc);
    check_eq("out_pc_plus4", bus.out_pc_plus4, e_pc4);
    check_eq("in_ready", {31'b0, bus.in_ready}, {31'b0, mq.size() < DEPTH});
    check_eq("count", {29'b0, bus.count}, mq.size());
  endtask

  // One clock: drive inputs, advance the reference at the edge, compare after it.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic r, input logic f);
    bit do_push;
    bit do_pop;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = p;
    bus.out_ready = r;
    bus.flush     = f;
    @(posedge clk);
    if (f) begin
      mq.delete();
    end else begin
      do_pop  = r && (mq.size() > 0);
      do_push = v && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({ins, p});
    end
    #1;
    compare_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle after reset
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    // 2: single word, visible the next cycle, then consumed
    step(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    // 3: stall and fill, extra word refused, drain in order
    for (int i = 0; i < 5; i++) step(1'b1, 32'h00100013 + i, 32'(i * 4), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    // 4: full with pop and in_valid together
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0000000 + i, 32'h40 + 32'(i * 4), 1'b0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 32'h80, 1'b1, 1'b0);
    // 5: flush at count=3 with a push pending
    step(1'b1, 32'hBAD00000, 32'h90, 1'b0, 1'b1);
    step(1'b1, 32'h12345678, 32'h100, 1'b0, 1'b0);
    // 6: wrap with count alternating 1..2, including the truncating pc+4
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hC0000000 + i, (i == 4) ? 32'hFFFFFFFC : 32'h200 + 32'(i * 4), 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    while (mq.size() != 0) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00000073, 32'hFFFFFFFC, 1'b0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0);
    end

    // asynchronous reset in mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    #2 rst = 1'b1;
    mq.delete();
    #1 compare_all();
    @(posedge clk);
    #1 rst = 1'b0;
    compare_all();
    step(1'b1, 32'h00A00113, 32'h300, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
